// File: rtl/ddr_arb_pkg.sv
// Shared definitions for the DDR port arbiter: FSM encoding, requester ids
// and the round-robin pointer advance helper.
package ddr_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_RD = 3'd2,
    ST_ACK     = 3'd3,
    ST_GAP     = 3'd4
  } arb_state_t;

  localparam logic [1:0] REQ_MI   = 2'd0;
  localparam logic [1:0] REQ_MO   = 2'd1;
  localparam logic [1:0] REQ_HOST = 2'd2;

  // Pointer moves to the requester after the one just served; 2 wraps to 0.
  function automatic logic [1:0] next_id(input logic [1:0] id);
    return (id >= REQ_HOST) ? REQ_MI : id + 2'd1;
  endfunction

endpackage

// File: rtl/ddr_port_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker. The search starts at ptr and
// wraps MI -> MO -> HOST. An out-of-range pointer (3) behaves like 0.
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] gnt_id,
  output logic       any
);

  // Priority search rotated by the pointer.
  always_comb begin
    gnt_id = 2'd0;
    any    = |req;
    case (ptr)
      2'd1: begin
        if (req[1])      gnt_id = 2'd1;
        else if (req[2]) gnt_id = 2'd2;
        else             gnt_id = 2'd0;
      end
      2'd2: begin
        if (req[2])      gnt_id = 2'd2;
        else if (req[0]) gnt_id = 2'd0;
        else             gnt_id = 2'd1;
      end
      default: begin
        if (req[0])      gnt_id = 2'd0;
        else if (req[1]) gnt_id = 2'd1;
        else             gnt_id = 2'd2;
      end
    endcase
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Shares one single-port DDR controller between processor read (MI),
// processor write (MO) and a host loader. One command in flight at a time.
//
// Handshakes: mem_cmd_valid is held with stable fields until the cycle where
// mem_cmd_ready is also high; that clock edge transfers the command. Level
// requests are held by the requester until its one-cycle ack; the GAP state
// after every ack gives the requester one cycle to drop the level.
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RD_MI,
  input  logic [ADDR_W-1:0] MI_add,
  output logic [DATA_W-1:0] MI_data,
  output logic              d_ready_re,
  input  logic              WR_MO,
  input  logic [ADDR_W-1:0] MO_add,
  input  logic [DATA_W-1:0] MO_data,
  output logic              d_ready_we,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_add,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_we,
  output logic [ADDR_W-1:0] mem_cmd_add,
  output logic [DATA_W-1:0] mem_cmd_wdata,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy,
  output logic              stray_rd,
  output logic [2:0]        dbg_state
);

  arb_state_t state_q, state_d;
  logic [1:0] grant_q;
  logic [1:0] ptr_q;
  logic [1:0] pick_id;
  logic       pick_any;

  rr_pick3 u_pick (
    .req    ({host_req, WR_MO, RD_MI}),
    .ptr    (ptr_q),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  // State register; reset returns to IDLE at once, dropping mem_cmd_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and decoded outputs.
  always_comb begin
    state_d       = state_q;
    mem_cmd_valid = 1'b0;
    d_ready_re    = 1'b0;
    d_ready_we    = 1'b0;
    host_ack      = 1'b0;
    busy          = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE:    if (pick_any) state_d = ST_ISSUE;
      ST_ISSUE: begin
        mem_cmd_valid = 1'b1;
        if (mem_cmd_ready) state_d = mem_cmd_we ? ST_ACK : ST_WAIT_RD;
      end
      ST_WAIT_RD: if (mem_rd_valid) state_d = ST_ACK;
      ST_ACK: begin
        d_ready_re = (grant_q == REQ_MI);
        d_ready_we = (grant_q == REQ_MO);
        host_ack   = (grant_q == REQ_HOST);
        state_d    = ST_GAP;
      end
      ST_GAP:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign dbg_state = state_q;

  // Command capture at grant, read-data capture, pointer advance, stray flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q       <= REQ_MI;
      ptr_q         <= REQ_MI;
      mem_cmd_we    <= 1'b0;
      mem_cmd_add   <= '0;
      mem_cmd_wdata <= '0;
      MI_data       <= '0;
      host_rdata    <= '0;
      stray_rd      <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && pick_any) begin
        grant_q <= pick_id;
        case (pick_id)
          REQ_MO: begin
            mem_cmd_we    <= 1'b1;
            mem_cmd_add   <= MO_add;
            mem_cmd_wdata <= MO_data;
          end
          REQ_HOST: begin
            mem_cmd_we    <= host_we;
            mem_cmd_add   <= host_add;
            mem_cmd_wdata <= host_wdata;
          end
          default: begin
            mem_cmd_we    <= 1'b0;
            mem_cmd_add   <= MI_add;
            mem_cmd_wdata <= '0;
          end
        endcase
      end
      if (state_q == ST_WAIT_RD && mem_rd_valid) begin
        if (grant_q == REQ_HOST) host_rdata <= mem_rd_data;
        else                     MI_data    <= mem_rd_data;
      end
      if (state_q == ST_ACK) ptr_q <= next_id(grant_q);
      if (mem_rd_valid && state_q != ST_WAIT_RD) stray_rd <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed bench for ddr_port_arbiter: reset, write, read, backpressure,
// round-robin contention and reset/stray-read behaviour.
module tb_ddr_port_arbiter;
  import ddr_arb_pkg::*;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;

  logic              clk;
  logic              rst;
  logic              RD_MI, WR_MO, host_req, host_we;
  logic [ADDR_W-1:0] MI_add, MO_add, host_add;
  logic [DATA_W-1:0] MO_data, host_wdata;
  logic [DATA_W-1:0] MI_data, host_rdata;
  logic              d_ready_re, d_ready_we, host_ack;
  logic              mem_cmd_valid, mem_cmd_ready, mem_cmd_we;
  logic [ADDR_W-1:0] mem_cmd_add;
  logic [DATA_W-1:0] mem_cmd_wdata;
  logic              mem_rd_valid;
  logic [DATA_W-1:0] mem_rd_data;
  logic              busy, stray_rd;
  logic [2:0]        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // responder controls
  bit         resp_en     = 1'b1;
  bit         rd_use_addr = 1'b0;
  int         rd_lat      = 2;
  logic [7:0] rd_ret      = 8'h00;

  logic [1:0] exp_q[$];

  ddr_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .RD_MI(RD_MI), .MI_add(MI_add), .MI_data(MI_data), .d_ready_re(d_ready_re),
    .WR_MO(WR_MO), .MO_add(MO_add), .MO_data(MO_data), .d_ready_we(d_ready_we),
    .host_req(host_req), .host_we(host_we), .host_add(host_add),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_we(mem_cmd_we), .mem_cmd_add(mem_cmd_add),
    .mem_cmd_wdata(mem_cmd_wdata), .mem_rd_valid(mem_rd_valid),
    .mem_rd_data(mem_rd_data), .busy(busy), .stray_rd(stray_rd),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for the ack of one requester: 0=MI, 1=MO, 2=HOST.
  task automatic wait_ack(input int which, input int max_cyc, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      case (which)
        0:       seen = d_ready_re;
        1:       seen = d_ready_we;
        default: seen = host_ack;
      endcase
    end
    if (!seen) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int max_cyc);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (dbg_state != ST_IDLE && c < max_cyc);
    if (dbg_state != ST_IDLE) chk("idle_timeout", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // DDR controller read responder: returns data rd_lat cycles after a read handshake.
  initial begin
    logic [ADDR_W-1:0] a;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    forever begin
      @(negedge clk);
      if (resp_en && rst && mem_cmd_valid && mem_cmd_ready && !mem_cmd_we) begin
        a = mem_cmd_add;
        repeat (rd_lat) @(negedge clk);
        mem_rd_valid = 1'b1;
        mem_rd_data  = rd_use_addr ? a[7:0] : rd_ret;
        @(negedge clk);
        mem_rd_valid = 1'b0;
      end
    end
  end

  initial begin
    int cyc, last, nack;
    logic [1:0] id;
    rst = 1'b0;
    RD_MI = 0; WR_MO = 0; host_req = 0; host_we = 0;
    MI_add = '0; MO_add = '0; host_add = '0; MO_data = '0; host_wdata = '0;
    mem_cmd_ready = 1'b1;

    // T1: requests high during reset
    RD_MI = 1; WR_MO = 1; host_req = 1; host_we = 1;
    MI_add = 19'h00AAA; MO_add = 19'h00BBB; host_add = 19'h00CCC;
    rd_lat = 2; rd_ret = 8'h11;
    repeat (3) @(negedge clk);
    chk("t1_valid", 32'(mem_cmd_valid), 0);
    chk("t1_acks", {d_ready_re, d_ready_we, host_ack}, 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_mi_data", 32'(MI_data), 0);
    chk("t1_host_rdata", 32'(host_rdata), 0);
    chk("t1_cmd_add", 32'(mem_cmd_add), 0);
    chk("t1_stray", 32'(stray_rd), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t1_first_valid", 32'(mem_cmd_valid), 1);
    chk("t1_first_we", 32'(mem_cmd_we), 0);
    chk("t1_first_add", 32'(mem_cmd_add), 32'h00AAA);
    wait_ack(0, 20, cyc);
    chk("t1_other_acks", {d_ready_we, host_ack}, 0);
    chk("t1_rd_data", 32'(MI_data), 32'h11);
    RD_MI = 0; WR_MO = 0; host_req = 0;
    wait_idle(10);

    // T2: uncontended write, ready high
    WR_MO = 1; MO_add = 19'h7FFFF; MO_data = 8'hA5;
    @(negedge clk);
    chk("t2_valid", 32'(mem_cmd_valid), 1);
    chk("t2_we", 32'(mem_cmd_we), 1);
    chk("t2_add", 32'(mem_cmd_add), 32'h7FFFF);
    chk("t2_wdata", 32'(mem_cmd_wdata), 32'hA5);
    chk("t2_no_early_ack", 32'(d_ready_we), 0);
    MO_add = 19'h00001; MO_data = 8'h00;
    @(negedge clk);
    chk("t2_ack", 32'(d_ready_we), 1);
    chk("t2_single_cmd", 32'(mem_cmd_valid), 0);
    WR_MO = 0;
    @(negedge clk);
    chk("t2_gap_busy", 32'(busy), 1);
    chk("t2_gap_noack", 32'(d_ready_we), 0);
    wait_idle(10);

    // T3: processor read, 5-cycle controller latency
    RD_MI = 1; MI_add = 19'h00010; rd_lat = 5; rd_ret = 8'h3C;
    @(negedge clk);
    chk("t3_add", 32'(mem_cmd_add), 32'h00010);
    wait_ack(0, 30, cyc);
    chk("t3_latency", 32'(cyc + 1), 32'd7);
    chk("t3_data", 32'(MI_data), 32'h3C);
    RD_MI = 0;
    rd_ret = 8'hEE;
    repeat (4) @(negedge clk);
    chk("t3_data_held", 32'(MI_data), 32'h3C);
    chk("t3_host_untouched", 32'(host_rdata), 0);
    chk("t3_no_stray", 32'(stray_rd), 0);

    // T5: host write under 10 cycles of backpressure
    mem_cmd_ready = 1'b0;
    host_req = 1; host_we = 1; host_add = 19'h12345; host_wdata = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_valid_held", 32'(mem_cmd_valid), 1);
      chk("t5_add_stable", 32'(mem_cmd_add), 32'h12345);
      chk("t5_no_ack", 32'(host_ack), 0);
      if (i == 3) begin host_add = 19'h00777; host_wdata = 8'hFF; end
    end
    chk("t5_wdata_stable", 32'(mem_cmd_wdata), 32'h5A);
    mem_cmd_ready = 1'b1;
    @(negedge clk);
    chk("t5_ack", 32'(host_ack), 1);
    host_req = 0;
    wait_idle(10);

    // T4: all three requesting continuously, pointer back at MI
    rd_use_addr = 1'b1; rd_lat = 1;
    MI_add = 19'h00021; MO_add = 19'h00033; MO_data = 8'h99;
    host_add = 19'h00042; host_we = 0;
    exp_q = {REQ_MI, REQ_MO, REQ_HOST, REQ_MI, REQ_MO, REQ_HOST};
    RD_MI = 1; WR_MO = 1; host_req = 1;
    cyc = 0; last = -10; nack = 0;
    while (nack < 6 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (d_ready_re || d_ready_we || host_ack) begin
        id = d_ready_re ? REQ_MI : (d_ready_we ? REQ_MO : REQ_HOST);
        chk("t4_onehot", 32'(d_ready_re) + 32'(d_ready_we) + 32'(host_ack), 1);
        chk("t4_order", 32'(id), 32'(exp_q.pop_front()));
        chk("t4_ack_spacing", 32'((cyc - last) >= 2), 1);
        last = cyc;
        nack++;
        if (nack == 6) begin RD_MI = 0; WR_MO = 0; host_req = 0; end
      end
    end
    if (nack < 6) chk("t4_timeout", 32'(nack), 6);
    wait_idle(10);
    chk("t4_mi_data", 32'(MI_data), 32'h21);
    chk("t4_host_rdata", 32'(host_rdata), 32'h42);

    // T6: reset while waiting for read data, then a stray read strobe
    resp_en = 1'b0;
    RD_MI = 1; MI_add = 19'h00055;
    cyc = 0;
    while (dbg_state != ST_WAIT_RD && cyc < 20) begin @(negedge clk); cyc++; end
    chk("t6_reached_wait", 32'(dbg_state), 32'(ST_WAIT_RD));
    rst = 1'b0;
    #1;
    chk("t6_async_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("t6_async_busy", 32'(busy), 0);
    chk("t6_mi_cleared", 32'(MI_data), 0);
    RD_MI = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_rd_valid = 1'b1; mem_rd_data = 8'hC3;
    @(negedge clk);
    mem_rd_valid = 1'b0;
    chk("t6_stray_set", 32'(stray_rd), 1);
    chk("t6_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("t6_no_ack", {d_ready_re, d_ready_we, host_ack}, 0);
    chk("t6_no_capture", 32'(MI_data), 0);
    repeat (3) @(negedge clk);
    chk("t6_stray_sticky", 32'(stray_rd), 1);
    rst = 1'b0;
    #1;
    chk("t6_stray_reset", 32'(stray_rd), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
